// File: rtl/req_mux_rr_pkg.sv
// Shared definitions for the cache-side request multiplexer: FSM encoding, flat-bus slicing
// and modulo-N index arithmetic.

`define CB_SLICE(bus_, idx_, w_) bus_[(idx_) * (w_) +: (w_)]

package cache_bus_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // (a + b) mod n for a, b < n; explicit wrap so non-power-of-two n never aliases.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/req_mux_rr_if.sv
// Requester-side and memory-side signals of the multiplexer, bundled as one interface.
// The slave modport is the multiplexer's view; master is the environment's.

interface req_mux_rr_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_we;
  logic [N*AW-1:0] in_addr;
  logic [N*DW-1:0] in_wdata;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   in_rdata;

  logic            out_valid;
  logic            out_we;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_wdata;
  logic            out_ready;
  logic [DW-1:0]   out_rdata;

  modport slave (
    input  in_valid, in_we, in_addr, in_wdata, out_ready, out_rdata,
    output in_ready, in_rdata, out_valid, out_we, out_addr, out_wdata
  );

  modport master (
    output in_valid, in_we, in_addr, in_wdata, out_ready, out_rdata,
    input  in_ready, in_rdata, out_valid, out_we, out_addr, out_wdata
  );

endinterface

// File: rtl/req_mux_rr_rr_pick.sv
// Round-robin winner selection: rotate requests by ptr_i, priority-encode, un-rotate.
// With ptr_i tied to zero this degenerates to lowest-index-wins.

module rr_pick
  import cache_bus_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req_i[IW'(wrap_add(32'(ptr_i), k, N))];
    end
  end

  // Descending scan so the lowest rotated offset wins.
  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = IW'(k);
      end
    end
  end

  assign idx_o = IW'(wrap_add(32'(ptr_i), 32'(off), N));

endmodule

// File: rtl/req_mux_rr.sv
// N-channel request multiplexer with grant hold until downstream completion.
// Define REQ_MUX_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.

module req_mux_rr
  import cache_bus_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  req_mux_rr_if.slave bus
);

  localparam int unsigned IW = $clog2(N);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          out_valid_q, out_valid_d;
  logic          out_we_q, out_we_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_wdata_q, out_wdata_d;

  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [N-1:0]  in_ready;

`ifdef REQ_MUX_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  assign pick_ptr = rr_ptr_q;
`endif

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (bus.in_valid),
    .ptr_i   (pick_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_we_d    = out_we_q;
    out_addr_d  = out_addr_q;
    out_wdata_d = out_wdata_q;
`ifndef REQ_MUX_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_BUSY;
          grant_d     = pick_idx;
          out_valid_d = 1'b1;
          out_we_d    = bus.in_we[pick_idx];
          out_addr_d  = `CB_SLICE(bus.in_addr, pick_idx, AW);
          out_wdata_d = `CB_SLICE(bus.in_wdata, pick_idx, DW);
        end
      end
      S_BUSY: begin
        // Completion always returns to IDLE, so back-to-back grants get one idle cycle.
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
`ifndef REQ_MUX_FIXED_PRIO_EN
          rr_ptr_d    = IW'(wrap_add(32'(grant_q), 1, N));
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
`ifndef REQ_MUX_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_wdata_q <= out_wdata_d;
`ifndef REQ_MUX_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = (state_q == S_BUSY) && bus.out_ready && (grant_q == IW'(i));
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.in_rdata  = bus.out_rdata;
  assign bus.out_valid = out_valid_q;
  assign bus.out_we    = out_we_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_wdata = out_wdata_q;

endmodule

// File: tb/tb_req_mux_rr.sv
// Directed bench for req_mux_rr: an N=2 instance for reset/single/payload/reset-abort cases
// and an N=3 instance for fairness and non-power-of-two wrap.

module tb_req_mux_rr;

  logic clk;
  logic rst2;
  logic rst3;
  int   checks;
  int   errors;

  req_mux_rr_if #(.N(2), .AW(32), .DW(32)) b2 ();
  req_mux_rr_if #(.N(3), .AW(32), .DW(32)) b3 ();

  req_mux_rr #(.N(2), .AW(32), .DW(32)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2)
  );

  req_mux_rr #(.N(3), .AW(32), .DW(32)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One N=3 transaction: arbitration edge, 1-cycle completion, then the idle cycle.
  task automatic txn3(input int exp_ch, input string tag);
    tick();
    chk({tag, " out_valid"}, 64'(b3.out_valid), 64'd1);
    chk({tag, " out_addr"}, 64'(b3.out_addr), 64'(32'h3000 + 32'(exp_ch) * 32'h10));
    b3.out_ready = 1'b1;
    b3.out_rdata = 32'hC0DE_0000 + 32'(exp_ch);
    #1;
    chk({tag, " in_ready"}, 64'(b3.in_ready), 64'(3'b001 << exp_ch));
    chk({tag, " in_rdata"}, 64'(b3.in_rdata), 64'(32'hC0DE_0000 + 32'(exp_ch)));
    tick();
    chk({tag, " idle gap"}, 64'(b3.out_valid), 64'd0);
    b3.out_ready = 1'b0;
  endtask

  int fair_exp[6];
  int wrap_exp[3];

  initial begin
    checks = 0;
    errors = 0;
`ifdef REQ_MUX_FIXED_PRIO_EN
    fair_exp = '{0, 0, 0, 0, 0, 0};
    wrap_exp = '{0, 0, 0};
`else
    fair_exp = '{0, 1, 2, 0, 1, 2};
    wrap_exp = '{2, 0, 2};
`endif
    b2.in_valid  = '0;
    b2.in_we     = '0;
    b2.in_addr   = '0;
    b2.in_wdata  = '0;
    b2.out_ready = 1'b0;
    b2.out_rdata = '0;
    b3.in_valid  = '0;
    b3.in_we     = '0;
    b3.in_addr   = '0;
    b3.in_wdata  = '0;
    b3.out_ready = 1'b0;
    b3.out_rdata = '0;
    rst2 = 1'b1;
    rst3 = 1'b1;

    // Reset held two cycles with every channel requesting.
    b2.in_valid = 2'b11;
    b2.in_addr  = {32'h0000_0200, 32'h0000_0100};
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst out_valid", 64'(b2.out_valid), 64'd0);
      chk("rst in_ready", 64'(b2.in_ready), 64'd0);
      chk("rst out_addr", 64'(b2.out_addr), 64'd0);
    end
    rst2 = 1'b0;
    tick();
    chk("first grant out_valid", 64'(b2.out_valid), 64'd1);
    chk("first grant ch0 addr", 64'(b2.out_addr), 64'h100);
    b2.out_ready = 1'b1;
    b2.out_rdata = 32'h0000_0011;
    #1;
    chk("first grant in_ready", 64'(b2.in_ready), 64'b01);
    tick();
    chk("first done out_valid", 64'(b2.out_valid), 64'd0);
    b2.out_ready = 1'b0;
    b2.in_valid  = 2'b00;

    // Single read request on ch1, completion three cycles after the request.
    tick();
    b2.in_valid      = 2'b10;
    b2.in_we         = 2'b00;
    b2.in_addr[32+:32] = 32'h1000_0040;
    tick();
    chk("single out_valid t+1", 64'(b2.out_valid), 64'd1);
    chk("single out_addr", 64'(b2.out_addr), 64'h1000_0040);
    chk("single out_we", 64'(b2.out_we), 64'd0);
    chk("single no early ready", 64'(b2.in_ready), 64'd0);
    tick();
    chk("single hold out_valid", 64'(b2.out_valid), 64'd1);
    chk("single hold in_ready", 64'(b2.in_ready), 64'd0);
    b2.out_ready = 1'b1;
    b2.out_rdata = 32'hDEAD_BEEF;
    #1;
    chk("single in_ready", 64'(b2.in_ready), 64'b10);
    chk("single in_rdata", 64'(b2.in_rdata), 64'hDEAD_BEEF);
    tick();
    chk("single done out_valid", 64'(b2.out_valid), 64'd0);
    b2.out_ready = 1'b0;
    b2.in_valid  = 2'b00;

    // Write on ch0; payload changes during BUSY must not reach the output.
    b2.in_valid        = 2'b01;
    b2.in_we           = 2'b01;
    b2.in_addr[0+:32]  = 32'h0000_00A0;
    b2.in_wdata[0+:32] = 32'h0000_0055;
    tick();
    chk("payload out_valid", 64'(b2.out_valid), 64'd1);
    chk("payload out_we", 64'(b2.out_we), 64'd1);
    chk("payload out_addr", 64'(b2.out_addr), 64'hA0);
    chk("payload out_wdata", 64'(b2.out_wdata), 64'h55);
    b2.in_addr[0+:32]  = 32'h0000_BEEF;
    b2.in_wdata[0+:32] = 32'h0000_0066;
    b2.in_we           = 2'b00;
    tick();
    chk("stable out_addr", 64'(b2.out_addr), 64'hA0);
    chk("stable out_wdata", 64'(b2.out_wdata), 64'h55);
    chk("stable out_we", 64'(b2.out_we), 64'd1);
    b2.out_ready = 1'b1;
    #1;
    chk("payload in_ready", 64'(b2.in_ready), 64'b01);
    tick();
    b2.out_ready = 1'b0;
    b2.in_valid  = 2'b00;

    // Reset while BUSY: outputs clear, no completion pulse, pointer back to ch0.
    b2.in_addr  = {32'h0000_0200, 32'h0000_0100};
    b2.in_valid = 2'b11;
    tick();
`ifdef REQ_MUX_FIXED_PRIO_EN
    chk("pre-abort grant", 64'(b2.out_addr), 64'h100);
`else
    chk("pre-abort grant", 64'(b2.out_addr), 64'h200);
`endif
    rst2 = 1'b1;
    tick();
    chk("abort out_valid", 64'(b2.out_valid), 64'd0);
    chk("abort out_addr", 64'(b2.out_addr), 64'd0);
    b2.out_ready = 1'b1;
    #1;
    chk("abort no in_ready", 64'(b2.in_ready), 64'd0);
    b2.out_ready = 1'b0;
    rst2 = 1'b0;
    tick();
    chk("post-abort grant ch0", 64'(b2.out_addr), 64'h100);
    b2.out_ready = 1'b1;
    #1;
    chk("post-abort in_ready", 64'(b2.in_ready), 64'b01);
    tick();
    b2.out_ready = 1'b0;
    b2.in_valid  = 2'b00;

    // N=3 fairness with all channels continuously requesting.
    b3.in_addr  = {32'h0000_3020, 32'h0000_3010, 32'h0000_3000};
    b3.in_valid = 3'b111;
    tick();
    rst3 = 1'b0;
    for (int t = 0; t < 6; t++) begin
      txn3(fair_exp[t], $sformatf("fair%0d", t));
    end

    // Non-power-of-two wrap: move pointer to 2, then only ch0 and ch2 request.
    b3.in_valid = 3'b010;
    txn3(1, "wrap setup");
    b3.in_valid = 3'b101;
    for (int t = 0; t < 3; t++) begin
      txn3(wrap_exp[t], $sformatf("wrap%0d", t));
    end
    b3.in_valid = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
